// File: rtl/gray_ptr_rx.sv
// Read-clock-domain side of an async FIFO: synchronises the gray write pointer,
// owns the read pointer and produces registered empty / level / integrity status.
module gray_ptr_rx #(
    parameter int unsigned addr_size   = 4,
    parameter int unsigned sync_stages = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [addr_size:0]   wr_gray_in,
    input  logic                 rd_en,
    input  logic                 err_clr,
    output logic [addr_size-1:0] rd_addr,
    output logic [addr_size:0]   rd_gray,
    output logic [addr_size:0]   wr_bin_sync,
    output logic                 empty,
    output logic [addr_size:0]   level,
    output logic                 rd_ack,
    output logic                 gray_err
);

    localparam int unsigned PW = addr_size + 1;
    localparam logic [addr_size:0] DEPTH = {1'b1, {addr_size{1'b0}}};

    if (sync_stages < 2 || sync_stages > 4) begin : g_bad_sync_stages
        $error("gray_ptr_rx: sync_stages must be in 2..4");
    end

    // Synchroniser chain packed as one shift register; stage 0 in the low PW bits.
    logic [sync_stages*PW-1:0] sync_q;
    logic [addr_size:0]        wr_gray_sync;
    logic [addr_size:0]        prev_q;

    logic [addr_size:0] rd_bin_q,      rd_bin_d;
    logic [addr_size:0] rd_gray_q,     rd_gray_d;
    logic [addr_size:0] wr_bin_sync_q, wr_bin_sync_d;
    logic               empty_q,       empty_d;
    logic [addr_size:0] level_q,       level_d;
    logic               gray_err_q,    gray_err_d;
    logic               gray_step_bad;
    logic               overrun;

    // Bit i of the binary value is the XOR of gray bits addr_size down to i.
    function automatic logic [addr_size:0] gray2bin(input logic [addr_size:0] g);
        logic [addr_size:0] b;
        b = g;
        for (int unsigned i = 1; i < PW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    always_comb begin
        wr_gray_sync  = sync_q[sync_stages*PW-1 -: PW];
        wr_bin_sync_d = gray2bin(wr_gray_sync);

        rd_ack    = rd_en & ~empty_q;
        rd_bin_d  = rd_bin_q + {{addr_size{1'b0}}, rd_ack};
        rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);

        // Full-width compare: equal MSBs are required, so a full lap never reads as empty.
        empty_d = (rd_gray_d == wr_gray_sync);
        level_d = wr_bin_sync_d - rd_bin_d;

        gray_step_bad = ($countones(wr_gray_sync ^ prev_q) > 1);
        overrun       = (level_d > DEPTH);

        gray_err_d = gray_err_q;
        if (err_clr) begin
            gray_err_d = 1'b0;
        end
        if (gray_step_bad || overrun) begin
            gray_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q        <= '0;
            prev_q        <= '0;
            rd_bin_q      <= '0;
            rd_gray_q     <= '0;
            wr_bin_sync_q <= '0;
            empty_q       <= 1'b1;
            level_q       <= '0;
            gray_err_q    <= 1'b0;
        end else begin
            sync_q        <= {sync_q[(sync_stages-1)*PW-1:0], wr_gray_in};
            prev_q        <= wr_gray_sync;
            rd_bin_q      <= rd_bin_d;
            rd_gray_q     <= rd_gray_d;
            wr_bin_sync_q <= wr_bin_sync_d;
            empty_q       <= empty_d;
            level_q       <= level_d;
            gray_err_q    <= gray_err_d;
        end
    end

    assign rd_addr     = rd_bin_q[addr_size-1:0];
    assign rd_gray     = rd_gray_q;
    assign wr_bin_sync = wr_bin_sync_q;
    assign empty       = empty_q;
    assign level       = level_q;
    assign gray_err    = gray_err_q;

endmodule

// File: tb/tb_gray_ptr_rx.sv
// Directed scoreboard bench for gray_ptr_rx with addr_size=4, sync_stages=2.
// Expectations are queued against an edge number and checked at the following negedge.
module tb_gray_ptr_rx;

    localparam int unsigned AS = 4;

    typedef enum int {S_EMPTY, S_LEVEL, S_RDADDR, S_RDGRAY, S_WRBIN, S_ERR, S_ACK} sel_e;

    typedef struct {
        int          edge_no;
        string       name;
        sel_e        sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   edge_cnt = 0;

    logic          clk;
    logic          reset_n;
    logic [AS:0]   wr_gray_in;
    logic          rd_en;
    logic          err_clr;
    logic [AS-1:0] rd_addr;
    logic [AS:0]   rd_gray;
    logic [AS:0]   wr_bin_sync;
    logic          empty;
    logic [AS:0]   level;
    logic          rd_ack;
    logic          gray_err;

    gray_ptr_rx #(
        .addr_size  (AS),
        .sync_stages(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_gray_in (wr_gray_in),
        .rd_en      (rd_en),
        .err_clr    (err_clr),
        .rd_addr    (rd_addr),
        .rd_gray    (rd_gray),
        .wr_bin_sync(wr_bin_sync),
        .empty      (empty),
        .level      (level),
        .rd_ack     (rd_ack),
        .gray_err   (gray_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [AS:0] gray(input int unsigned b);
        logic [AS:0] x;
        x = 5'(b % 32);
        return x ^ (x >> 1);
    endfunction

    function automatic logic [31:0] actual(input sel_e s);
        case (s)
            S_EMPTY:  return {31'd0, empty};
            S_LEVEL:  return {27'd0, level};
            S_RDADDR: return {28'd0, rd_addr};
            S_RDGRAY: return {27'd0, rd_gray};
            S_WRBIN:  return {27'd0, wr_bin_sync};
            S_ERR:    return {31'd0, gray_err};
            default:  return {31'd0, rd_ack};
        endcase
    endfunction

    task automatic expect_at(input int e, input string nm, input sel_e s, input logic [31:0] v);
        exp_t x;
        x.edge_no = e;
        x.name    = nm;
        x.sel     = s;
        x.val     = v;
        exp_q.push_back(x);
    endtask

    task automatic check(input exp_t x);
        logic [31:0] a;
        a = actual(x.sel);
        n_checks++;
        if (x.edge_no != edge_cnt)
            $display("FAIL %s: due at edge %0d but checked at edge %0d, got %0d expected %0d",
                     x.name, x.edge_no, edge_cnt, a, x.val);
        else if (a !== x.val)
            $display("FAIL %s @edge %0d: got %0d expected %0d", x.name, edge_cnt, a, x.val);
        else
            n_pass++;
    endtask

    // Monitor: every negedge, compare all expectations due at the current edge.
    initial begin
        forever begin
            int i;
            @(negedge clk);
            i = 0;
            while (i < exp_q.size()) begin
                if (exp_q[i].edge_no <= edge_cnt) begin
                    check(exp_q[i]);
                    exp_q.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          e;
    logic [AS:0] lap_end_gray [2];

    initial begin
        lap_end_gray[0] = 5'b11000;
        lap_end_gray[1] = 5'b00000;

        reset_n    = 1'b0;
        rd_en      = 1'b0;
        err_clr    = 1'b0;
        wr_gray_in = 5'($urandom);

        // Reset values while reset_n is held low
        tick();
        e = edge_cnt;
        expect_at(e, "rst_empty",  S_EMPTY,  1);
        expect_at(e, "rst_level",  S_LEVEL,  0);
        expect_at(e, "rst_rdaddr", S_RDADDR, 0);
        expect_at(e, "rst_rdgray", S_RDGRAY, 0);
        expect_at(e, "rst_err",    S_ERR,    0);
        expect_at(e, "rst_wrbin",  S_WRBIN,  0);
        tick();
        reset_n    = 1'b1;
        wr_gray_in = '0;
        tick();

        // Single write: visible in empty/level three edges after the input changes
        e = edge_cnt;
        wr_gray_in = 5'b00001;
        expect_at(e+1, "sw_empty_e1", S_EMPTY, 1);
        expect_at(e+2, "sw_empty_e2", S_EMPTY, 1);
        expect_at(e+2, "sw_level_e2", S_LEVEL, 0);
        expect_at(e+2, "sw_wrbin_e2", S_WRBIN, 0);
        expect_at(e+3, "sw_empty",    S_EMPTY, 0);
        expect_at(e+3, "sw_level",    S_LEVEL, 1);
        expect_at(e+3, "sw_wrbin",    S_WRBIN, 1);
        repeat (3) tick();
        rd_en = 1'b1;
        e = edge_cnt;
        expect_at(e,   "sw_ack",    S_ACK,    1);
        expect_at(e+1, "sr_rdaddr", S_RDADDR, 1);
        expect_at(e+1, "sr_rdgray", S_RDGRAY, 1);
        expect_at(e+1, "sr_empty",  S_EMPTY,  1);
        expect_at(e+1, "sr_level",  S_LEVEL,  0);
        tick();

        // Read on empty: rd_en held for five more cycles
        e = edge_cnt;
        for (int k = 0; k < 5; k++) begin
            expect_at(e+k, $sformatf("roe_ack_%0d", k),    S_ACK,    0);
            expect_at(e+k, $sformatf("roe_rdaddr_%0d", k), S_RDADDR, 1);
        end
        repeat (5) tick();
        rd_en = 1'b0;
        e = edge_cnt;
        expect_at(e, "roe_err",   S_ERR,   0);
        expect_at(e, "roe_level", S_LEVEL, 0);

        // Fresh pointers for the fill/drain laps
        reset_n = 1'b0;
        tick();
        reset_n    = 1'b1;
        wr_gray_in = '0;
        tick();

        for (int lap = 0; lap < 2; lap++) begin
            for (int i = 1; i <= 16; i++) begin
                e = edge_cnt;
                wr_gray_in = gray(16*lap + i);
                expect_at(e+3, $sformatf("fill%0d_level_%0d", lap, i), S_LEVEL, i);
                tick();
            end
            tick();
            tick();
            e = edge_cnt;
            expect_at(e, $sformatf("fill%0d_wrbin", lap), S_WRBIN, (16*lap + 16) % 32);
            expect_at(e, $sformatf("fill%0d_empty", lap), S_EMPTY, 0);
            expect_at(e, $sformatf("fill%0d_err", lap),   S_ERR,   0);

            rd_en = 1'b1;
            expect_at(e, $sformatf("drain%0d_ack", lap), S_ACK, 1);
            for (int j = 1; j <= 16; j++) begin
                expect_at(e+j, $sformatf("drain%0d_level_%0d", lap, j),  S_LEVEL,  16 - j);
                expect_at(e+j, $sformatf("drain%0d_rdaddr_%0d", lap, j), S_RDADDR, j % 16);
            end
            repeat (16) tick();
            rd_en = 1'b0;
            e = edge_cnt;
            expect_at(e, $sformatf("drain%0d_rdgray", lap), S_RDGRAY, {27'd0, lap_end_gray[lap]});
            expect_at(e, $sformatf("drain%0d_empty", lap),  S_EMPTY,  1);
            expect_at(e, $sformatf("drain%0d_err", lap),    S_ERR,    0);
            tick();
        end

        // Simultaneous read and write-pointer advance at level 3
        for (int i = 1; i <= 3; i++) begin
            wr_gray_in = gray(i);
            tick();
        end
        tick();
        tick();
        e = edge_cnt;
        expect_at(e, "sim_level_pre", S_LEVEL, 3);
        wr_gray_in = gray(4);
        tick();
        tick();
        rd_en = 1'b1;
        expect_at(e+2, "sim_ack",      S_ACK,    1);
        expect_at(e+2, "sim_level_e2", S_LEVEL,  3);
        expect_at(e+3, "sim_level",    S_LEVEL,  3);
        expect_at(e+3, "sim_empty",    S_EMPTY,  0);
        expect_at(e+3, "sim_rdaddr",   S_RDADDR, 1);
        expect_at(e+4, "sim_level_e4", S_LEVEL,  3);
        tick();
        rd_en = 1'b0;
        tick();

        // Grow to level 7, then reset asynchronously mid-cycle
        for (int i = 5; i <= 8; i++) begin
            wr_gray_in = gray(i);
            tick();
        end
        tick();
        tick();
        e = edge_cnt;
        expect_at(e, "mid_level_7", S_LEVEL, 7);
        tick();
        reset_n = 1'b0;
        e = edge_cnt;
        expect_at(e, "mid_rst_empty",  S_EMPTY,  1);
        expect_at(e, "mid_rst_level",  S_LEVEL,  0);
        expect_at(e, "mid_rst_rdaddr", S_RDADDR, 0);
        expect_at(e, "mid_rst_rdgray", S_RDGRAY, 0);
        expect_at(e, "mid_rst_wrbin",  S_WRBIN,  0);
        wr_gray_in = '0;
        tick();
        reset_n = 1'b1;
        e = edge_cnt;
        for (int k = 1; k <= 3; k++) begin
            expect_at(e+k, $sformatf("post_rst_empty_%0d", k), S_EMPTY, 1);
            expect_at(e+k, $sformatf("post_rst_level_%0d", k), S_LEVEL, 0);
        end
        repeat (3) tick();

        // Integrity: multi-bit jump 00001 -> 00110
        wr_gray_in = 5'b00001;
        repeat (3) tick();
        e = edge_cnt;
        wr_gray_in = 5'b00110;
        expect_at(e+2, "int_err_e2",   S_ERR,   0);
        expect_at(e+3, "int_err_e3",   S_ERR,   1);
        expect_at(e+3, "int_level",    S_LEVEL, 4);
        expect_at(e+5, "int_err_held", S_ERR,   1);
        repeat (5) tick();

        e = edge_cnt;
        err_clr = 1'b1;
        expect_at(e,   "clr_err_before", S_ERR, 1);
        expect_at(e+1, "clr_err_after",  S_ERR, 0);
        expect_at(e+2, "clr_err_stays",  S_ERR, 0);
        tick();
        err_clr = 1'b0;
        tick();

        // Clear coincident with a new violation: set wins
        e = edge_cnt;
        wr_gray_in = 5'b01001;
        expect_at(e+2, "coin_err_e2", S_ERR, 0);
        expect_at(e+3, "coin_err_e3", S_ERR, 1);
        expect_at(e+4, "coin_err_e4", S_ERR, 1);
        tick();
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        while (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s: never checked, got none expected %0d", exp_q[0].name, exp_q[0].val);
            void'(exp_q.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gray_ptr_rx.md
Name: gray_ptr_rx

Overview:
- Read-side pointer block for the asynchronous FIFO, in the read clock domain; it is the receiving end of the gray-coded write pointer.
- Synchronises the incoming gray write pointer and decodes it back to binary.
- Maintains the local read pointer, in binary and gray, and generates registered empty, level and pointer-integrity status.
- Its gray read pointer output is returned to the write domain.

Parameters:
- addr_size, 4, FIFO address width; depth = 2**addr_size; pointers carry one extra MSB for wrap detection.
- sync_stages, 2, number of flops in the write-pointer synchroniser chain (legal: 2..4).

Ports:
- clk  input  1  read-domain clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- wr_gray_in  input  addr_size+1  gray-coded write pointer from the write domain; asynchronous to clk.
- rd_en  input  1  read request for the current cycle.
- err_clr  input  1  clears gray_err.
- rd_addr  output  addr_size  binary read address for the RAM; equals rd_bin[addr_size-1:0].
- rd_gray  output  addr_size+1  registered gray read pointer, sent to the write domain.
- wr_bin_sync  output  addr_size+1  synchronised write pointer, decoded to binary.
- empty  output  1  registered empty flag.
- level  output  addr_size+1  registered occupancy, 0..2**addr_size.
- rd_ack  output  1  read accepted this cycle (combinational: rd_en & ~empty).
- gray_err  output  1  sticky pointer-integrity error.

Behaviour:
- Reset is asynchronous and active-low. Values held in reset:
  - all synchroniser flops 0; rd_bin 0; rd_gray 0; wr_bin_sync 0;
  - empty 1; level 0; gray_err 0.
- Synchroniser:
  - s[0] <= wr_gray_in; s[i] <= s[i-1].
  - wr_gray_sync = s[sync_stages-1]. No logic is allowed between stages.
- Gray-to-binary decode of wr_gray_sync:
  - b[addr_size] = g[addr_size]; b[i] = b[i+1] ^ g[i] for i = addr_size-1 down to 0.
  - The decoded value is registered into wr_bin_sync.
- Read pointer:
  - rd_bin_next = rd_bin + (rd_en & ~empty), modulo 2**(addr_size+1).
  - rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1).
  - Both rd_bin and rd_gray are registered every cycle.
  - rd_en while empty is ignored: no pointer change, no error.
- Empty:
  - empty <= (rd_gray_next == wr_gray_sync).
  - This is a full-width compare; the MSB differs when the pointers are one lap apart.
- Level:
  - level <= (wr_bin_sync_next - rd_bin_next) modulo 2**(addr_size+1).
  - wr_bin_sync_next is the decode of the current wr_gray_sync.
  - level == 0 exactly when empty == 1.
- Latency:
  - A wr_gray_in change sampled at edge k reaches wr_gray_sync at edge k+sync_stages-1.
  - empty and level reflect it after edge k+sync_stages.
  - A read accepted at edge k is reflected in rd_addr, rd_gray, empty and level after edge k.
- Integrity check:
  - A previous-value register holds wr_gray_sync.
  - gray_err sets if popcount(wr_gray_sync ^ prev) > 1.
  - gray_err also sets if the computed level exceeds 2**addr_size (overrun).
  - Once set, gray_err holds until err_clr; set takes priority over clear in the same cycle.
- Pointer updates:
  - A simultaneous read and write-pointer update in the same cycle must both take effect; level is net of the two.
- Wrap-around:
  - Pointers wrap from 2**(addr_size+1)-1 to 0 with no special handling.
  - With addr_size=4, the gray sequence must pass 5'b10000 -> 5'b00000.
- Reset asserted mid-operation:
  - All state returns to reset values immediately, with no clock required.
  - The first post-reset cycle behaves as a fresh FIFO.

Test Plan:
- Reset: assert reset_n=0 with random wr_gray_in -> empty=1, level=0, rd_addr=0, rd_gray=0, gray_err=0, all asynchronous to clk.
- Single write visibility: wr_gray_in 0 -> 5'b00001 between edges 0 and 1 (sync_stages=2) -> empty falls and level=1 after edge 3, not earlier. Then rd_en=1 for one cycle -> rd_ack=1, rd_addr=1, empty=1, level=0 after the next edge.
- Fill and drain with wrap-around:
  - Step wr_gray_in through gray 1..16 -> level=16 and wr_bin_sync=16.
  - Drain 16 reads -> rd_gray=5'b11000 and empty=1.
  - Repeat one more lap -> pointers wrap to 0 and level stays consistent.
- Read on empty: rd_en=1 held for 5 cycles while empty -> rd_ack=0, rd_addr unchanged, gray_err=0.
- Simultaneous events: with level=3, issue a read in the same cycle the write pointer advances by one -> level=3 after settling, empty=0.
- Integrity: jump wr_gray_in 5'b00001 -> 5'b00110 -> gray_err=1 two edges later and held. Pulse err_clr with a clean sequence -> gray_err=0. err_clr coincident with a new violation -> gray_err stays 1.
- Reset mid-operation: at level=7, pulse reset_n low -> empty=1 and level=0 immediately. After release, with wr_gray_in=0 -> the block remains empty.
